// File: rtl/mac_18_acc_seq.sv
// Frame accumulator behind the 18-bit MAC: sums LEN unsigned results into a
// wide register and offers the total (plus a sticky carry-out flag) on valid/ready.
module mac_18_acc_seq #(
  parameter int DATA_WIDTH = 18,
  parameter int ACC_WIDTH  = 40,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_ovf,
  output logic                  busy
);

  // state   | meaning
  // IDLE    | waiting for start; len sampled here only
  // ACCUM   | accepting beats, cnt counts down remaining beats
  // HOLD    | total presented, waiting for out_ready
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  logic [ACC_WIDTH:0]     sum;
  logic                   beat;

  // Handshake outputs decode the state register only, so they carry no input paths.
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

  assign beat = in_valid & in_ready;
  assign sum  = {1'b0, acc_q} + (ACC_WIDTH + 1)'(in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = S_ACCUM;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_ACCUM: begin
        if (beat) begin
          acc_d = sum[ACC_WIDTH-1:0];
          ovf_d = ovf_q | sum[ACC_WIDTH];
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_18_acc_seq.sv
// Directed bench for mac_18_acc_seq: default 40-bit instance plus a 20-bit
// instance sharing the same stimulus to exercise wrap and the overflow flag.
module tb_mac_18_acc_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [17:0] in_data;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf, busy;
  logic [39:0] out_data;
  logic        in_ready_w, out_valid_w, out_ovf_w, busy_w;
  logic [19:0] out_data_w;

  int n_chk;
  int n_err;

  mac_18_acc_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .busy(busy)
  );

  mac_18_acc_seq #(.ACC_WIDTH(20)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .out_ovf(out_ovf_w), .busy(busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [17:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    len = 8'd0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // 1: len=4, 1..4 back-to-back; len changed after start must not matter
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0; len = 8'd9;
    chk("t1_in_ready", in_ready, 1);
    chk("t1_busy", busy, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("t1_not_valid_yet", out_valid, 0);
      beat(18'(i));
    end
    chk("t1_out_valid", out_valid, 1);
    chk("t1_in_ready_hold", in_ready, 0);
    chk("t1_out_data", out_data, 10);
    chk("t1_out_ovf", out_ovf, 0);
    step();
    chk("t1_idle_valid", out_valid, 0);
    chk("t1_idle_busy", busy, 0);

    // 2: len=3, 5/7/9 with two bubbles between beats
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    beat(18'd5);
    for (int b = 0; b < 2; b++) begin
      in_data = 18'd1000;
      step();
      chk("t2_bubble_ready", in_ready, 1);
      chk("t2_bubble_acc", out_data, 5);
    end
    beat(18'd7);
    step();
    step();
    beat(18'd9);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_data", out_data, 21);
    step();
    chk("t2_idle", busy, 0);

    // 3: zero-length frame; presented beats must be ignored
    start = 1'b1; len = 8'd0;
    in_valid = 1'b1; in_data = 18'd99;
    step();
    start = 1'b0;
    chk("t3_out_valid", out_valid, 1);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_out_data", out_data, 0);
    chk("t3_out_ovf", out_ovf, 0);
    step();
    in_valid = 1'b0;
    chk("t3_idle", out_valid, 0);
    chk("t3_no_consume", out_data, 0);

    // 4: 5 x 262143 on both instances; 20-bit one wraps and flags overflow
    start = 1'b1; len = 8'd5;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) beat(18'd262143);
    chk("t4_valid_w", out_valid_w, 1);
    chk("t4_data_w", out_data_w, (5 * 262143) % (1 << 20));
    chk("t4_ovf_w", out_ovf_w, 1);
    chk("t4_data_40", out_data, 5 * 262143);
    chk("t4_ovf_40", out_ovf, 0);
    step();

    // 5: backpressure for 3 cycles, start pulses during HOLD ignored
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    beat(18'd100);
    beat(18'd200);
    for (int h = 0; h < 3; h++) begin
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_data", out_data, 300);
      chk("t5_hold_busy", busy, 1);
      start = (h != 1); len = 8'd7;
      step();
    end
    chk("t5_hold_valid4", out_valid, 1);
    chk("t5_hold_data4", out_data, 300);
    chk("t5_ovf_cleared_w", out_ovf_w, 0);
    chk("t5_data_w", out_data_w, 300);
    out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_idle_after_hs", busy, 0);
    chk("t5_start_ignored", in_ready, 0);
    step();
    chk("t5_still_idle", busy, 0);

    // 6: async reset mid-frame, then a clean len=1 frame
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    beat(18'd11);
    beat(18'd13);
    chk("t6_partial", out_data, 24);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_out_data", out_data, 0);
    chk("t6_rst_out_ovf", out_ovf, 0);
    chk("t6_rst_busy", busy, 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("t6_no_output", out_valid, 0);
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    beat(18'd42);
    chk("t6_out_valid", out_valid, 1);
    chk("t6_out_data", out_data, 42);
    chk("t6_out_ovf", out_ovf, 0);
    step();
    chk("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
